// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32 execute-stage ALU with valid/ready handshakes.
//
// Single-cycle ops (logic, add/sub, compares, shifts) produce a result one
// cycle after acceptance. MUL/MULHU (and DIVU/REMU when ALU_SEQ_DIV_EN is
// defined) iterate one bit per cycle for WIDTH cycles. The registered result
// and Zero flag are held in DONE until out_ready is seen.
//
// Optional feature macro: ALU_SEQ_DIV_EN (iterative restoring divider).
// Without it DIVU/REMU fall into the "unknown opcode" path and return 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   data1, data2          operands A and B
//   ALU_control           4-bit opcode, sampled at acceptance
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   ALU_result, Zero      registered result and result==0 flag
//   busy                  multi-cycle operation in progress
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             Zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   multi_res;
    logic               multi_op;
    logic               last_step;

    // Multiply: acc = {partial product, remaining multiplier bits}. The adder
    // keeps its carry so the right shift never loses the top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // Divide: acc = {partial remainder, dividend/quotient shift register}.
    // A zero divisor always "succeeds", which naturally yields quotient
    // all-ones and remainder A, so no special case is needed.
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b_q};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign multi_op  = (ALU_control[3:2] == 2'b10);
`else
    assign multi_op  = (ALU_control[3:1] == 3'b100);
`endif

    assign last_step = (cnt == SHW'(WIDTH - 1));

    always_comb begin
        single_res = '0;
        case (ALU_control)
            4'b0000: single_res = data1 & data2;
            4'b0001: single_res = data1 | data2;
            4'b0010: single_res = data1 + data2;
            4'b0110: single_res = data1 - data2;
            4'b0011: single_res = data1 ^ data2;
            4'b0111: single_res = WIDTH'($signed(data1) < $signed(data2));
            4'b1111: single_res = WIDTH'(data1 < data2);
            4'b0100: single_res = data1 << data2[SHW-1:0];
            4'b0101: single_res = data1 >> data2[SHW-1:0];
            4'b1101: single_res = WIDTH'($signed(data1) >>> data2[SHW-1:0]);
            default: single_res = '0;
        endcase
    end

    // Result of the final iteration, taken from the step's next value so the
    // last step and the result load happen on the same edge.
    always_comb begin
        multi_res = '0;
        case (op_q)
            4'b1000: multi_res = mul_next[WIDTH-1:0];
            4'b1001: multi_res = mul_next[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
            4'b1010: multi_res = div_next[WIDTH-1:0];
            4'b1011: multi_res = div_next[2*WIDTH-1:WIDTH];
`endif
            default: multi_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = multi_op ? BUSY : DONE;
            end
            BUSY: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            a_q        <= '0;
            acc        <= '0;
            cnt        <= '0;
            ALU_result <= '0;
            Zero       <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            b_q        <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= ALU_control;
                    a_q  <= data1;
                    cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
                    b_q  <= data2;
                    acc  <= {{WIDTH{1'b0}}, ALU_control[1] ? data1 : data2};
`else
                    acc  <= {{WIDTH{1'b0}}, data2};
`endif
                    if (!multi_op) begin
                        ALU_result <= single_res;
                        Zero       <= (single_res == '0);
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    acc <= op_q[1] ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                    if (last_step) begin
                        ALU_result <= multi_res;
                        Zero       <= (multi_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
